// File: rtl/regfile_pkg.sv
// regfile_pkg: condition-code constants and type shared by the register file and ALU flag path
package regfile_pkg;
  typedef logic [2:0] cc_t;
  localparam cc_t CC_N = 3'b100;
  localparam cc_t CC_Z = 3'b010;
  localparam cc_t CC_P = 3'b001;
endpackage

// File: rtl/regfile_nzp_if.sv
// regfile_nzp_if: write, reserve and read-port bundle of the register file
interface regfile_nzp_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2
);
  import regfile_pkg::*;
  localparam int SEL_W = $clog2(NUM_REGS);
  logic              write_en;
  logic [SEL_W-1:0]  sel_in;
  logic [DATA_W-1:0] in;
  logic              cc_en;
  logic              reserve_en;
  logic [SEL_W-1:0]  sel_reserve;
  logic [SEL_W-1:0]  sel_out [NUM_RD];
  logic [DATA_W-1:0] out [NUM_RD];
  logic [NUM_RD-1:0] busy;
  cc_t               cc;
  modport master (
    output write_en, sel_in, in, cc_en, reserve_en, sel_reserve, sel_out,
    input  out, busy, cc
  );
  modport slave (
    input  write_en, sel_in, in, cc_en, reserve_en, sel_reserve, sel_out,
    output out, busy, cc
  );
endinterface

// File: rtl/regfile_nzp_nzp_gen.sv
// nzp_gen: classifies a data word as negative, zero or positive
module nzp_gen
  import regfile_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_data,
  output cc_t               o_cc
);
  assign o_cc = i_data[DATA_W-1] ? CC_N : (i_data == '0) ? CC_Z : CC_P;
endmodule

// File: rtl/regfile_nzp.sv
// regfile_nzp: N-read/1-write register file with NZP condition codes and busy scoreboard
module regfile_nzp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          rst,
  regfile_nzp_if.slave bus
);
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  cc_t                 r_cc;
  cc_t                 w_nzp;
  nzp_gen #(.DATA_W(DATA_W)) u_nzp (.i_data(bus.in), .o_cc(w_nzp));
  // reserve is applied after the write clear so a new producer keeps the register busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.write_en) w_busy_nxt[bus.sel_in] = 1'b0;
    if (bus.reserve_en) w_busy_nxt[bus.sel_reserve] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
      r_cc   <= CC_Z;
    end else begin
      if (bus.write_en) r_regs[bus.sel_in] <= bus.in;
      if (bus.write_en && bus.cc_en) r_cc <= w_nzp;
      r_busy <= w_busy_nxt;
    end
  end
  assign bus.cc = r_cc;
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic w_hit;
    assign w_hit        = (BYPASS != 0) && !rst && bus.write_en && (bus.sel_out[p] == bus.sel_in);
    assign bus.out[p]   = w_hit ? bus.in : r_regs[bus.sel_out[p]];
    assign bus.busy[p]  = !w_hit && r_busy[bus.sel_out[p]];
  end
endmodule

// File: tb/tb_regfile_nzp.sv
// tb_regfile_nzp: directed table, random model comparison and wide-config check for regfile_nzp
module tb_regfile_nzp;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  always #5 clk = ~clk;

  regfile_nzp_if #(.DATA_W(16), .NUM_REGS(8),  .NUM_RD(2)) ifa ();
  regfile_nzp_if #(.DATA_W(16), .NUM_REGS(8),  .NUM_RD(2)) ifb ();
  regfile_nzp_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) ifc ();
  regfile_nzp_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) ifd ();

  regfile_nzp #(.DATA_W(16), .NUM_REGS(8),  .NUM_RD(2), .BYPASS(1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  regfile_nzp #(.DATA_W(16), .NUM_REGS(8),  .NUM_RD(2), .BYPASS(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  regfile_nzp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3), .BYPASS(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));
  regfile_nzp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3), .BYPASS(0)) u_d (.clk(clk), .rst(rst), .bus(ifd));

  typedef struct {
    logic r, we;
    logic [2:0] si;
    logic [15:0] d;
    logic ce, re;
    logic [2:0] sr, s0, s1;
    logic [15:0] a0, a1;
    logic ab0, ab1;
    logic [15:0] b0;
    logic bb0;
    logic [2:0] cc;
  } vec_t;
  vec_t tv [15];

  logic [15:0] m_regs [8];
  logic [7:0]  m_busy;
  logic [2:0]  m_cc;

  function automatic logic [2:0] nzp_ref(input logic [15:0] v);
    return ($signed(v) < 0) ? 3'b100 : (v == 16'd0) ? 3'b010 : 3'b001;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic we, input logic [2:0] si, input logic [15:0] d,
                       input logic ce, input logic re, input logic [2:0] sr,
                       input logic [2:0] s0, input logic [2:0] s1);
    rst = r;
    ifa.write_en = we; ifa.sel_in = si; ifa.in = d; ifa.cc_en = ce;
    ifa.reserve_en = re; ifa.sel_reserve = sr; ifa.sel_out[0] = s0; ifa.sel_out[1] = s1;
    ifb.write_en = we; ifb.sel_in = si; ifb.in = d; ifb.cc_en = ce;
    ifb.reserve_en = re; ifb.sel_reserve = sr; ifb.sel_out[0] = s0; ifb.sel_out[1] = s1;
  endtask

  task automatic bapply(input logic we, input logic [3:0] si, input logic [31:0] d,
                        input logic ce, input logic [3:0] s);
    ifc.write_en = we; ifc.sel_in = si; ifc.in = d; ifc.cc_en = ce;
    ifc.reserve_en = 1'b0; ifc.sel_reserve = '0;
    ifd.write_en = we; ifd.sel_in = si; ifd.in = d; ifd.cc_en = ce;
    ifd.reserve_en = 1'b0; ifd.sel_reserve = '0;
    for (int k = 0; k < 3; k++) begin
      ifc.sel_out[k] = s;
      ifd.sel_out[k] = s;
    end
  endtask

  task automatic upd();
    if (rst) begin
      for (int k = 0; k < 8; k++) m_regs[k] = '0;
      m_busy = '0;
      m_cc   = 3'b010;
    end else begin
      if (ifa.write_en) begin
        m_regs[ifa.sel_in] = ifa.in;
        m_busy[ifa.sel_in] = 1'b0;
        if (ifa.cc_en) m_cc = nzp_ref(ifa.in);
      end
      if (ifa.reserve_en) m_busy[ifa.sel_reserve] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    upd();
    #1;
  endtask

  initial begin
    tv[0]  = '{0,0,0,16'h0000,0,0,0,0,1, 16'h0000,16'h0000,0,0,16'h0000,0,3'b010};
    tv[1]  = '{0,1,0,16'hFFFF,1,0,0,0,1, 16'hFFFF,16'h0000,0,0,16'h0000,0,3'b010};
    tv[2]  = '{0,1,1,16'h0000,1,0,0,0,1, 16'hFFFF,16'h0000,0,0,16'hFFFF,0,3'b100};
    tv[3]  = '{0,1,2,16'h0001,0,0,0,2,0, 16'h0001,16'hFFFF,0,0,16'h0000,0,3'b010};
    tv[4]  = '{0,1,1,16'h0001,0,0,0,1,1, 16'h0001,16'h0001,0,0,16'h0000,0,3'b010};
    tv[5]  = '{0,0,0,16'h0000,0,0,0,1,0, 16'h0001,16'hFFFF,0,0,16'h0001,0,3'b010};
    tv[6]  = '{0,0,0,16'h0000,0,1,3,3,3, 16'h0000,16'h0000,0,0,16'h0000,0,3'b010};
    tv[7]  = '{0,0,0,16'h0000,0,0,0,3,2, 16'h0000,16'h0001,1,0,16'h0000,1,3'b010};
    tv[8]  = '{0,1,3,16'h00AA,0,0,0,3,3, 16'h00AA,16'h00AA,0,0,16'h0000,1,3'b010};
    tv[9]  = '{0,0,0,16'h0000,0,0,0,3,3, 16'h00AA,16'h00AA,0,0,16'h00AA,0,3'b010};
    tv[10] = '{0,1,3,16'h0055,1,1,3,3,3, 16'h0055,16'h0055,0,0,16'h00AA,0,3'b010};
    tv[11] = '{0,0,0,16'h0000,0,0,0,3,3, 16'h0055,16'h0055,1,1,16'h0055,1,3'b001};
    tv[12] = '{0,1,5,16'h1234,1,1,5,5,5, 16'h1234,16'h1234,0,0,16'h0000,0,3'b001};
    tv[13] = '{1,1,5,16'hFFFF,1,1,5,5,5, 16'h1234,16'h1234,1,1,16'h1234,1,3'b001};
    tv[14] = '{0,0,0,16'h0000,0,0,0,5,3, 16'h0000,16'h0000,0,0,16'h0000,0,3'b010};
    bapply(1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    // reset cycle carries a write, cc update and reserve that must all be discarded
    apply(1, 1, 3'd0, 16'hFFFF, 1, 1, 3'd0, 3'd0, 3'd1);
    bapply(1'b1, 4'd15, 32'hFFFF_FFFF, 1'b1, 4'd15);
    tick();
    bapply(1'b0, 4'd0, 32'd0, 1'b0, 4'd15);
    for (int t = 0; t < 15; t++) begin
      apply(tv[t].r, tv[t].we, tv[t].si, tv[t].d, tv[t].ce, tv[t].re, tv[t].sr, tv[t].s0, tv[t].s1);
      @(negedge clk);
      chk($sformatf("v%0d bp1 out0", t),  64'(ifa.out[0]), 64'(tv[t].a0));
      chk($sformatf("v%0d bp1 out1", t),  64'(ifa.out[1]), 64'(tv[t].a1));
      chk($sformatf("v%0d bp1 busy0", t), 64'(ifa.busy[0]), 64'(tv[t].ab0));
      chk($sformatf("v%0d bp1 busy1", t), 64'(ifa.busy[1]), 64'(tv[t].ab1));
      chk($sformatf("v%0d bp0 out0", t),  64'(ifb.out[0]), 64'(tv[t].b0));
      chk($sformatf("v%0d bp0 busy0", t), 64'(ifb.busy[0]), 64'(tv[t].bb0));
      chk($sformatf("v%0d bp1 cc", t),    64'(ifa.cc), 64'(tv[t].cc));
      chk($sformatf("v%0d bp0 cc", t),    64'(ifb.cc), 64'(tv[t].cc));
      tick();
    end
    for (int t = 0; t < 400; t++) begin
      apply($urandom_range(0, 39) == 0, 1'($urandom), 3'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      if ($urandom_range(0, 7) == 0) ifa.in = 16'h0000;
      ifb.in = ifa.in;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        logic [2:0] s;
        logic hit;
        s   = ifa.sel_out[p];
        hit = !rst && ifa.write_en && (s == ifa.sel_in);
        chk($sformatf("rnd%0d bp1 out%0d", t, p),  64'(ifa.out[p]), 64'(hit ? ifa.in : m_regs[s]));
        chk($sformatf("rnd%0d bp1 busy%0d", t, p), 64'(ifa.busy[p]), 64'(hit ? 1'b0 : m_busy[s]));
        chk($sformatf("rnd%0d bp0 out%0d", t, p),  64'(ifb.out[p]), 64'(m_regs[s]));
        chk($sformatf("rnd%0d bp0 busy%0d", t, p), 64'(ifb.busy[p]), 64'(m_busy[s]));
      end
      chk($sformatf("rnd%0d cc", t), 64'({ifa.cc, ifb.cc}), 64'({m_cc, m_cc}));
      tick();
    end
    // wide configuration: reset, then write a negative value to the top register
    apply(1, 0, 3'd0, 16'h0, 0, 0, 3'd0, 3'd0, 3'd0);
    bapply(1'b0, 4'd0, 32'd0, 1'b0, 4'd15);
    tick();
    apply(0, 0, 3'd0, 16'h0, 0, 0, 3'd0, 3'd0, 3'd0);
    bapply(1'b1, 4'd15, 32'h8000_0000, 1'b1, 4'd15);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wide bp1 same-cycle out%0d", k), 64'(ifc.out[k]), 64'h8000_0000);
      chk($sformatf("wide bp0 same-cycle out%0d", k), 64'(ifd.out[k]), 64'h0);
    end
    chk("wide cc before", 64'({ifc.cc, ifd.cc}), 64'({3'b010, 3'b010}));
    tick();
    bapply(1'b0, 4'd0, 32'd0, 1'b0, 4'd15);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wide bp1 stored out%0d", k), 64'(ifc.out[k]), 64'h8000_0000);
      chk($sformatf("wide bp0 stored out%0d", k), 64'(ifd.out[k]), 64'h8000_0000);
    end
    chk("wide bp1 cc", 64'(ifc.cc), 64'(3'b100));
    chk("wide bp0 cc", 64'(ifd.cc), 64'(3'b100));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
